// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes x - y one bit per cycle, LSB first,
// and reports the WIDTH-bit difference plus the final borrow with a done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowOut
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] xReg;
  logic [WIDTH-1:0] yReg;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] resNext;
  logic [CntW-1:0]  bitCnt;
  logic             borrow;
  logic             diffBit;
  logic             borrowNext;
  logic             lastBit;

  // State register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Full-subtractor bit slice and next-state decode
  always_comb begin
    stateNext  = state;
    diffBit    = xReg[0] ^ yReg[0] ^ borrow;
    borrowNext = (~xReg[0] & yReg[0]) | (~(xReg[0] ^ yReg[0]) & borrow);
    // New difference bit enters at the MSB; the result slides toward bit 0.
    resNext    = WIDTH'({diffBit, resReg} >> 1);
    lastBit    = (bitCnt == CntW'(WIDTH - 1));
    case (state)
      IDLE:    if (start) stateNext = SHIFT;
      SHIFT:   if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand/result datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      xReg       <= '0;
      yReg       <= '0;
      resReg     <= '0;
      bitCnt     <= '0;
      borrow     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrowOut  <= 1'b0;
    end else begin
      busy <= (stateNext == SHIFT);
      done <= (stateNext == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            xReg   <= x;
            yReg   <= y;
            resReg <= '0;
            bitCnt <= '0;
            borrow <= 1'b0;
          end
        end
        SHIFT: begin
          xReg   <= xReg >> 1;
          yReg   <= yReg >> 1;
          resReg <= resNext;
          borrow <= borrowNext;
          bitCnt <= bitCnt + CntW'(1);
          // Publish only when the final bit pair completes.
          if (lastBit) begin
            difference <= resNext;
            borrowOut  <= borrowNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [7:0] difference;
  logic       borrowOut;

  logic       start2;
  logic [1:0] x2;
  logic [1:0] y2;
  logic       busy2;
  logic       done2;
  logic [1:0] difference2;
  logic       borrowOut2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .resetN(resetN), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .difference(difference), .borrowOut(borrowOut)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .resetN(resetN), .start(start2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .difference(difference2), .borrowOut(borrowOut2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runOp8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expD, input logic expB, input string tag);
    int cyc;
    int busyCnt;
    x = a; y = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; busyCnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busyCnt++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busycycles"}, busyCnt, 8);
    check({tag, "_diff"}, difference, expD);
    check({tag, "_borrow"}, borrowOut, expB);
    check({tag, "_busy_at_done"}, busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_diff_hold"}, difference, expD);
  endtask

  task automatic runOp2(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] expD, input logic expB);
    int cyc;
    int busyCnt;
    x2 = a; y2 = b; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0; busyCnt = 0;
    while (done2 !== 1'b1 && cyc < 10) begin
      if (busy2 === 1'b1) busyCnt++;
      tick();
      cyc++;
    end
    check($sformatf("w2_%0d_%0d_latency", a, b), cyc, 2);
    check($sformatf("w2_%0d_%0d_busy", a, b), busyCnt, 2);
    check($sformatf("w2_%0d_%0d_diff", a, b), difference2, expD);
    check($sformatf("w2_%0d_%0d_borrow", a, b), borrowOut2, expB);
    tick();
    check($sformatf("w2_%0d_%0d_done_one", a, b), done2, 0);
  endtask

  initial begin
    int pulses;
    int busyCycles;
    int lastT;
    logic [7:0] expD;
    logic       expB;
    logic [7:0] heldD;
    logic       heldB;

    resetN = 1'b0; start = 1'b0; x = '0; y = '0;
    start2 = 1'b0; x2 = '0; y2 = '0;

    // Reset values
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", difference, 8'h00);
    check("rst_borrow", borrowOut, 0);

    // Start on the first edge out of reset, then the basic vectors
    resetN = 1'b1;
    runOp8(8'h05, 8'h03, 8'h02, 1'b0, "sub_05_03");
    runOp8(8'h03, 8'h05, 8'hFE, 1'b1, "sub_03_05");
    runOp8(8'h00, 8'h01, 8'hFF, 1'b1, "sub_00_01");
    runOp8(8'hFF, 8'hFF, 8'h00, 1'b0, "sub_FF_FF");
    runOp8(8'h80, 8'h01, 8'h7F, 1'b0, "sub_80_01");
    runOp8(8'h00, 8'hFF, 8'h01, 1'b1, "sub_00_FF");

    // start and operands disturbed during SHIFT
    x = 8'h5A; y = 8'h13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; x = 8'hFF; y = 8'h00;
    tick();
    tick();
    start = 1'b0;
    pulses = 0; busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) begin
        pulses++;
        check("disturb_diff", difference, 8'h47);
        check("disturb_borrow", borrowOut, 0);
      end
    end
    check("disturb_pulses", pulses, 1);
    check("disturb_busy_tail", busyCycles, 3);

    // Reset on the 4th SHIFT cycle
    x = 8'h10; y = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_busy_before", busy, 1);
    check("midrst_hold_before", difference, 8'h47);
    resetN = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", difference, 8'h00);
    check("midrst_borrow", borrowOut, 0);
    resetN = 1'b1;
    pulses = 0; busyCycles = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busyCycles++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_no_busy", busyCycles, 0);
    check("midrst_diff_after", difference, 8'h00);

    // start held high: one result every 10 cycles
    x = 8'h20; y = 8'h05; start = 1'b1;
    expD = 8'h1B; expB = 1'b0;
    heldD = 8'h00; heldB = 1'b0;
    pulses = 0; lastT = -1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (lastT < 0) check("b2b_first", t, 8);
        else check("b2b_period", t - lastT, 10);
        lastT = t;
        check("b2b_diff", difference, expD);
        check("b2b_borrow", borrowOut, expB);
        heldD = expD; heldB = expB;
        if (pulses == 1) begin
          x = 8'h01; y = 8'h02; expD = 8'hFF; expB = 1'b1;
        end else begin
          x = 8'h64; y = 8'h32; expD = 8'h32; expB = 1'b0;
        end
      end else if (lastT >= 0) begin
        check("b2b_hold_diff", difference, heldD);
        check("b2b_hold_borrow", borrowOut, heldB);
      end
    end
    start = 1'b0;
    check("b2b_pulses", pulses, 3);

    // WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        runOp2(2'(a), 2'(b), 2'((a - b) & 3), (a < b) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
